// File: rtl/imem_arbiter.sv
// Two-port instruction-memory arbiter: a fetch port and a loader/debug port share one
// single-port memory, with round-robin arbitration, a loader lock and a fetch starvation guard.
module imem_arbiter #(
  parameter int DEPTH_LOG2 = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch port
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  output logic                  f_err,
  // loader / debug port
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  input  logic                  l_lock,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [31:0]           l_rdata,
  output logic                  l_err,
  // memory side
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_L = 1'b1
  } owner_e;

  owner_e          last_q, last_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            rsp_vld_q, rsp_vld_d;
  owner_e          rsp_own_q, rsp_own_d;
  logic            rsp_err_q, rsp_err_d;

  logic            any_gnt;
  logic [31:0]     acc_addr;
  logic            acc_err;
  logic            acc_we;
  logic [31:0]     rsp_data;

  // Misaligned or beyond the last implemented word.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
  endfunction

  // Grant selection; the starvation guard overrides the loader lock.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      if (f_req && l_req) begin
        if (wait_q == WAIT_MAX) begin
          f_gnt = 1'b1;
        end else if (l_lock) begin
          l_gnt = 1'b1;
        end else if (last_q == OWN_L) begin
          f_gnt = 1'b1;
        end else begin
          l_gnt = 1'b1;
        end
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    end
  end

  always_comb begin
    any_gnt   = f_gnt | l_gnt;
    acc_addr  = l_gnt ? l_addr : f_addr;
    acc_err   = addr_err(acc_addr);
    acc_we    = l_gnt & l_we;
    mem_en    = any_gnt & ~acc_err;
    mem_we    = mem_en & acc_we;
    mem_addr  = mem_en ? acc_addr[DEPTH_LOG2+1:2] : '0;
    mem_wdata = mem_we ? l_wdata : 32'd0;
  end

  always_comb begin
    last_d = last_q;
    if (f_gnt) begin
      last_d = OWN_F;
    end else if (l_gnt) begin
      last_d = OWN_L;
    end

    wait_d = '0;
    if (f_req && !f_gnt) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + CW'(1);
    end

    // Plain writes complete silently; reads and every error get a response.
    rsp_vld_d = any_gnt & (acc_err | ~acc_we);
    rsp_own_d = l_gnt ? OWN_L : OWN_F;
    rsp_err_d = any_gnt & acc_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= OWN_L;
      wait_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_own_q <= OWN_F;
      rsp_err_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      wait_q    <= wait_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_own_q <= rsp_own_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Response stage: memory data arrives one cycle after the strobe.
  always_comb begin
    rsp_data = rsp_err_q ? 32'd0 : mem_rdata;
    f_rvalid = rsp_vld_q & (rsp_own_q == OWN_F);
    l_rvalid = rsp_vld_q & (rsp_own_q == OWN_L);
    f_rdata  = f_rvalid ? rsp_data : 32'd0;
    l_rdata  = l_rvalid ? rsp_data : 32'd0;
    f_err    = f_rvalid & rsp_err_q;
    l_err    = l_rvalid & rsp_err_q;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of instruction-memory depth in 32-bit words (256 words = 1 KB).
REQ-002 Parameter MAX_WAIT, default 4, maximum consecutive cycles fetch may be denied while loader lock is active.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 f_req  in  1  fetch request; held with f_addr stable until granted.
REQ-006 f_addr  in  32  fetch byte address.
REQ-007 f_gnt  out  1  fetch request accepted this cycle (combinational).
REQ-008 f_rvalid  out  1  fetch read response valid, one-cycle pulse.
REQ-009 f_rdata  out  32  fetch read data, meaningful only when f_rvalid=1.
REQ-010 f_err  out  1  fetch response is an error; qualified by f_rvalid.
REQ-011 l_req  in  1  loader/debug request; held with l_we, l_addr and l_wdata stable until granted.
REQ-012 l_we  in  1  loader write (1) or read (0).
REQ-013 l_addr  in  32  loader byte address.
REQ-014 l_wdata  in  32  loader write data.
REQ-015 l_lock  in  1  loader priority lock.
REQ-016 l_gnt  out  1  loader request accepted this cycle (combinational).
REQ-017 l_rvalid  out  1  loader response valid, one-cycle pulse; issued for reads and for erroring writes.
REQ-018 l_rdata  out  32  loader read data.
REQ-019 l_err  out  1  loader response is an error; qualified by l_rvalid.
REQ-020 mem_en  out  1  memory access strobe.
REQ-021 mem_we  out  1  memory write enable.
REQ-022 mem_addr  out  DEPTH_LOG2  memory word index.
REQ-023 mem_wdata  out  32  memory write data.
REQ-024 mem_rdata  in  32  memory read data, valid the cycle after a read strobe.

Function
REQ-025 At most one of f_gnt and l_gnt is high in any cycle; a grant is issued in the same cycle as the request; req&gnt consumes the request.
REQ-026 With a single requester, that requester is granted.
REQ-027 Arbitration when both request: round-robin against the last_owner register; the requester that was not last granted wins.
REQ-028 When l_lock=1 and l_req=1, the loader wins regardless of last_owner, subject to REQ-029.
REQ-029 Starvation counter: increments each cycle f_req=1 and f_gnt=0, saturates at MAX_WAIT, and clears when f_gnt=1 or f_req=0; when the counter equals MAX_WAIT, fetch wins over the lock.
REQ-030 last_owner updates to the granted requester on every grant and holds otherwise.
REQ-031 Error address: addr[1:0]!=0 (misaligned) or addr[31:DEPTH_LOG2+2]!=0 (out of range).
REQ-032 Granted, non-error access: mem_en=1; mem_addr=addr[DEPTH_LOG2+1:2]; mem_we=l_we for a loader grant, 0 for a fetch grant; mem_wdata=l_wdata.
REQ-033 Granted error access: mem_en=0 and mem_we=0; the request is still consumed.
REQ-034 mem_wdata=0 when no loader write is granted.
REQ-035 Response pipeline: one registered stage holding owner, is_read, err. The cycle after a grant, the owner's rvalid pulses for a read or for any error, with rdata=mem_rdata (0 on error) and err=1 on error.
REQ-036 A non-error write produces no response.
REQ-037 Latency: grant to read response is exactly 1 cycle; back-to-back grants give back-to-back responses with no bubbles.
REQ-038 The non-owner's rvalid, rdata and err are 0.

Reset
REQ-039 While rst_n=0, all outputs are 0, last_owner=loader (fetch wins the first conflict), the starvation counter is 0, and the response stage is empty.
REQ-040 Reset asserted with a response in flight drops that response; no rvalid appears after reset release.

Verification
REQ-041 Reset release, then f_req=1 with f_addr=0x8 -> f_gnt=1, mem_addr=2; next cycle f_rvalid=1, f_rdata=mem word 2, f_err=0.
REQ-042 f_req and l_req both held high for 4 cycles, l_lock=0 -> grants alternate F,L,F,L.
REQ-043 l_we=1, l_addr=0x0C, l_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=3, no l_rvalid; a subsequent fetch of 0x0C returns 0xDEADBEEF.
REQ-044 Error accesses: f_addr=0x6 -> mem_en=0, next cycle f_rvalid=1, f_err=1, f_rdata=0; l_addr=0x400 write -> l_rvalid=1, l_err=1, memory unchanged.
REQ-045 l_lock=1 with l_req and f_req held continuously -> loader granted 4 cycles, fetch granted on cycle 5, counter cleared.
REQ-046 rst_n driven low in the cycle after a granted read -> no rvalid appears, and all outputs are 0 while rst_n=0.
